// File: rtl/pipeline24_feeder_pkg.sv
// Shared constants, state encoding and small helpers for the 24-permutation pipeline feeder.
package pipeline24_feeder_pkg;

    localparam int         PF_ADDR_WIDTH     = 8;
    localparam logic [4:0] PF_FULLNESS_LIMIT = 5'd20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } feeder_state_e;

    // Issue is allowed only while the pack's worst FIFO is strictly below the limit.
    function automatic logic can_issue(input logic [4:0] fullness, input logic [4:0] limit);
        return (fullness < limit);
    endfunction

endpackage

// File: rtl/pipeline24_feeder.sv
// Streams one job of bots against a latched top function into the pipeline pack,
// throttled by the pack's worst-case FIFO fullness, then waits for the pack to empty.
module pipeline24_feeder
    import pipeline24_feeder_pkg::*;
#(
    parameter int         ADDR_WIDTH     = PF_ADDR_WIDTH,
    parameter logic [4:0] FULLNESS_LIMIT = PF_FULLNESS_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [127:0]          topIn,
    input  logic [ADDR_WIDTH:0]   botCount,
    input  logic                  srcValid,
    input  logic [127:0]          srcData,
    output logic                  srcReady,
    input  logic [4:0]            maxFullness,
    output logic [127:0]          top,
    output logic [127:0]          bot,
    output logic [ADDR_WIDTH-1:0] botIndex,
    output logic                  isBotValid,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    feeder_state_e         r_state;
    logic [127:0]          r_top;
    logic [127:0]          r_bot;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_issued;
    logic [ADDR_WIDTH-1:0] r_bot_index;
    logic                  r_bot_valid;

    logic w_ready;
    logic w_xfer;
    logic w_last;
    logic w_done;

    assign w_ready = (r_state == ST_STREAM) && can_issue(maxFullness, FULLNESS_LIMIT)
                     && (r_issued < r_count);
    assign w_xfer  = srcValid && w_ready;
    assign w_last  = (r_issued == (r_count - CNT_ONE));
    // Drain completes once nothing is in flight from us and the pack reports empty.
    assign w_done  = (r_state == ST_DRAIN) && !r_bot_valid && (maxFullness == 5'd0);

    assign srcReady   = w_ready;
    assign top        = r_top;
    assign bot        = r_bot;
    assign botIndex   = r_bot_index;
    assign isBotValid = r_bot_valid;
    assign busy       = (r_state != ST_IDLE);
    assign done       = w_done;

    // Job control, issue counter and registered pack-input outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_top       <= 128'd0;
            r_bot       <= 128'd0;
            r_count     <= '0;
            r_issued    <= '0;
            r_bot_index <= '0;
            r_bot_valid <= 1'b0;
        end else begin
            r_bot_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_top    <= topIn;
                        r_count  <= botCount;
                        r_issued <= '0;
                        r_state  <= (botCount == '0) ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_bot       <= srcData;
                        r_bot_index <= r_issued[ADDR_WIDTH-1:0];
                        r_bot_valid <= 1'b1;
                        r_issued    <= r_issued + CNT_ONE;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline24_feeder.sv
// Directed bench for pipeline24_feeder: each job is run cycle by cycle from a per-test
// input pattern and the observed issue/done timeline is compared with hand-worked values.
module tb_pipeline24_feeder;
    import pipeline24_feeder_pkg::*;

    localparam int AW = PF_ADDR_WIDTH;

    logic          clk;
    logic          rst;
    logic          start;
    logic [127:0]  topIn;
    logic [AW:0]   botCount;
    logic          srcValid;
    logic [127:0]  srcData;
    logic          srcReady;
    logic [4:0]    maxFullness;
    logic [127:0]  top;
    logic [127:0]  bot;
    logic [AW-1:0] botIndex;
    logic          isBotValid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    int           vq[$];
    int           iq[$];
    logic [127:0] bq[$];
    int           ev[$];
    int           done_cyc;
    int           done_cnt;
    int           stall_ready_hi;
    int           top_bad;
    logic         busy_at_done;
    logic         busy_after;
    logic [127:0] cur_top;
    logic [127:0] data_base;

    pipeline24_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .topIn      (topIn),
        .botCount   (botCount),
        .srcValid   (srcValid),
        .srcData    (srcData),
        .srcReady   (srcReady),
        .maxFullness(maxFullness),
        .top        (top),
        .bot        (bot),
        .botIndex   (botIndex),
        .isBotValid (isBotValid),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic pat_valid(input int tid, input int c);
        case (tid)
            1:       return 1'b0;
            3:       return (c <= 4) && ((c % 2) == 0);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [4:0] pat_full(input int tid, input int c);
        case (tid)
            2:       return (c >= 3 && c <= 6) ? 5'd20 : 5'd0;
            4:       return (c >= 2 && c <= 11) ? 5'd7 : 5'd0;
            default: return 5'd0;
        endcase
    endfunction

    task automatic do_start(input logic [127:0] t, input logic [AW:0] n);
        @(negedge clk);
        start    = 1'b1;
        topIn    = t;
        botCount = n;
        srcValid = 1'b0;
        cur_top  = t;
    endtask

    // Cycle c=0 is the first cycle after the start was accepted; stops one cycle after done.
    task automatic run_job(input int tid, input int max_cyc);
        int k;
        k = 0;
        vq.delete(); iq.delete(); bq.delete();
        done_cyc = -1; done_cnt = 0; stall_ready_hi = 0; top_bad = 0;
        busy_at_done = 1'b0; busy_after = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            start       = 1'b0;
            srcValid    = pat_valid(tid, c);
            srcData     = data_base + 128'(k);
            maxFullness = pat_full(tid, c);
            if (tid == 4 && (c == 5 || c == 12)) begin
                start    = 1'b1;
                topIn    = {4{32'hDEAD_BEEF}};
                botCount = (AW+1)'(5);
            end
            #1;
            if (isBotValid) begin
                vq.push_back(c);
                iq.push_back(int'(botIndex));
                bq.push_back(bot);
            end
            if (srcReady && maxFullness >= 5'd20) stall_ready_hi++;
            if (top !== cur_top) top_bad++;
            if (srcValid && srcReady) k++;
            if (done_cyc >= 0) begin
                busy_after = busy;
                break;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = c;
                busy_at_done = busy;
            end
        end
        start       = 1'b0;
        srcValid    = 1'b0;
        maxFullness = 5'd0;
    endtask

    task automatic check_job(input string name, input int exp_done);
        check_eq({name, "_nvalid"}, 128'(vq.size()), 128'(ev.size()));
        for (int i = 0; i < ev.size(); i++) begin
            if (i < vq.size()) begin
                check_eq($sformatf("%s_vcyc%0d", name, i), 128'(vq[i]), 128'(ev[i]));
                check_eq($sformatf("%s_idx%0d", name, i), 128'(iq[i]), 128'(i));
                check_eq($sformatf("%s_bot%0d", name, i), bq[i], data_base + 128'(i));
            end
        end
        check_eq({name, "_done_cyc"}, 128'(done_cyc), 128'(exp_done));
        check_eq({name, "_done_cnt"}, 128'(done_cnt), 128'(1));
        check_eq({name, "_busy_at_done"}, 128'(busy_at_done), 128'(1));
        check_eq({name, "_busy_after"}, 128'(busy_after), 128'(0));
        check_eq({name, "_top_const"}, 128'(top_bad), 128'(0));
        check_eq({name, "_stall_ready"}, 128'(stall_ready_hi), 128'(0));
    endtask

    initial begin
        int nv;
        int nd;
        rst = 1'b0; start = 1'b0; topIn = 128'd0; botCount = '0;
        srcValid = 1'b0; srcData = 128'd0; maxFullness = 5'd0;
        cur_top = 128'd0; data_base = 128'd0;
        #3;
        check_eq("rst_top", top, 128'd0);
        check_eq("rst_bot", bot, 128'd0);
        check_eq("rst_idx", 128'(botIndex), 128'd0);
        check_eq("rst_valid", 128'(isBotValid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Four bots, always valid, no back-pressure.
        data_base = 128'd0;
        do_start({4{32'h1234_5678}}, (AW+1)'(4));
        run_job(0, 40);
        ev = '{1, 2, 3, 4};
        check_job("basic4", 5);

        // Empty job goes straight to drain.
        do_start({4{32'hA5A5_0F0F}}, (AW+1)'(0));
        run_job(1, 40);
        ev.delete();
        check_job("empty", 0);

        // Eight bots with the pack full during cycles 3..6.
        data_base = 128'h1000;
        do_start({4{32'h0BAD_CAFE}}, (AW+1)'(8));
        run_job(2, 60);
        ev = '{1, 2, 3, 8, 9, 10, 11, 12};
        check_job("stall8", 13);

        // Three bots with a toggling source.
        data_base = 128'h2000;
        do_start({4{32'hFEED_0001}}, (AW+1)'(3));
        run_job(3, 40);
        ev = '{1, 3, 5};
        check_job("toggle3", 6);

        // Long drain with ignored starts during it.
        data_base = 128'h3000;
        do_start({4{32'h7777_1111}}, (AW+1)'(2));
        run_job(4, 40);
        ev = '{1, 2};
        check_job("drain", 12);
        check_eq("drain_top_kept", top, {4{32'h7777_1111}});

        // Reset in the middle of a six-bot job after two bots were seen.
        data_base = 128'h4000;
        do_start({4{32'h5555_AAAA}}, (AW+1)'(6));
        run_job(5, 3);
        check_eq("mid_pre_valid", 128'(isBotValid), 128'd1);
        rst = 1'b0;
        #1;
        check_eq("mid_top", top, 128'd0);
        check_eq("mid_bot", bot, 128'd0);
        check_eq("mid_idx", 128'(botIndex), 128'd0);
        check_eq("mid_valid", 128'(isBotValid), 128'd0);
        check_eq("mid_busy", 128'(busy), 128'd0);
        check_eq("mid_done", 128'(done), 128'd0);
        check_eq("mid_ready", 128'(srcReady), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        srcValid = 1'b1;
        nv = 0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (isBotValid) nv++;
            if (done) nd++;
        end
        check_eq("post_rst_valid", 128'(nv), 128'd0);
        check_eq("post_rst_done", 128'(nd), 128'd0);
        check_eq("post_rst_busy", 128'(busy), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
